// File: rtl/rsa_multicore_ctrl.sv
// -----------------------------------------------------------------------------
// rsa_multicore_ctrl
//   Command/data front-end between the ARM handshake bus and NUM_CORES
//   modular-exponentiation cores. Decodes 32-bit commands, loads shared
//   operands (E, M, R, R2, t) and a per-core X, launches cores one at a time
//   or all together (non-blocking), and returns each core's result to the ARM.
//
//   Handshakes: a transfer happens on a rising clk edge where valid and ready
//   are both high; valid never waits for ready, and once the controller raises
//   fpga_to_arm_data_valid the data stays stable until that transfer.
//
// Ports
//   clk, resetn                      clock, asynchronous active-low reset
//   arm_to_fpga_cmd[_valid]          command word ([3:0] op, [7:4] id, [31:22] t)
//   arm_to_fpga_done / _done_read    command-finished flag and its acknowledge
//   arm_to_fpga_data[_valid/_ready]  inbound operand channel
//   fpga_to_arm_data[_valid/_ready]  outbound result channel
//   core_x/e/m/r/r2/t                operands driven continuously to the cores
//   core_start                       one-cycle start pulse per core
//   core_busy/done/result            per-core status and result
//   leds                             [0] busy FSM, [1] any core busy,
//                                    [2] any result pending, [3] sticky error
// -----------------------------------------------------------------------------
module rsa_multicore_ctrl #(
    parameter int DATA_W    = 1024,
    parameter int NUM_CORES = 2,
    parameter int TLEN_W    = 10
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic [31:0]                   arm_to_fpga_cmd,
    input  logic                          arm_to_fpga_cmd_valid,
    output logic                          arm_to_fpga_done,
    input  logic                          arm_to_fpga_done_read,
    input  logic                          arm_to_fpga_data_valid,
    output logic                          arm_to_fpga_data_ready,
    input  logic [DATA_W-1:0]             arm_to_fpga_data,
    output logic                          fpga_to_arm_data_valid,
    input  logic                          fpga_to_arm_data_ready,
    output logic [DATA_W-1:0]             fpga_to_arm_data,
    output logic [NUM_CORES*DATA_W-1:0]   core_x,
    output logic [DATA_W-1:0]             core_e,
    output logic [DATA_W-1:0]             core_m,
    output logic [DATA_W-1:0]             core_r,
    output logic [DATA_W-1:0]             core_r2,
    output logic [TLEN_W-1:0]             core_t,
    output logic [NUM_CORES-1:0]          core_start,
    input  logic [NUM_CORES-1:0]          core_busy,
    input  logic [NUM_CORES-1:0]          core_done,
    input  logic [NUM_CORES*DATA_W-1:0]   core_result,
    output logic [3:0]                    leds
);

    localparam logic [3:0] OP_COMPUTE     = 4'd0;
    localparam logic [3:0] OP_READ_X      = 4'd1;
    localparam logic [3:0] OP_WRITE_RES   = 4'd2;
    localparam logic [3:0] OP_READ_E      = 4'd3;
    localparam logic [3:0] OP_READ_R      = 4'd5;
    localparam logic [3:0] OP_READ_R2     = 4'd7;
    localparam logic [3:0] OP_READ_M      = 4'd9;
    localparam logic [3:0] OP_COMPUTE_ALL = 4'd11;
    localparam logic [4:0] NC             = 5'(NUM_CORES);

    typedef enum logic [2:0] {
        S_IDLE, S_RX_DATA, S_LAUNCH, S_WAIT_RES, S_TX_DATA, S_SIGNAL_DONE
    } state_t;

    state_t                        r_state, w_state_nxt;
    logic [3:0]                    r_op, r_id;
    logic [NUM_CORES*DATA_W-1:0]   r_x;
    logic [DATA_W-1:0]             r_e, r_m, r_r, r_r2, r_tx_data;
    logic [TLEN_W-1:0]             r_t;
    logic [NUM_CORES-1:0]          r_pending;
    logic                          r_err;

    logic [3:0]                    w_cmd_op, w_cmd_id;
    logic                          w_cmd_id_ok, w_cmd_err, w_launch_err;
    logic                          w_rx_fire, w_tx_fire, w_pend_sel;
    logic [NUM_CORES-1:0]          w_id_onehot, w_launch_req, w_launch_go;
    logic [DATA_W-1:0]             w_res_sel;
    logic                          w_unused_cmd;

    assign w_cmd_op     = arm_to_fpga_cmd[3:0];
    assign w_cmd_id     = arm_to_fpga_cmd[7:4];
    assign w_cmd_id_ok  = ({1'b0, w_cmd_id} < NC);
    assign w_unused_cmd = ^arm_to_fpga_cmd[21:8];

    // Per-core selection by the latched id, written as a compare loop so
    // out-of-range ids simply select nothing.
    always_comb begin
        w_id_onehot = '0;
        w_pend_sel  = 1'b0;
        w_res_sel   = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            if (r_id == 4'(i)) begin
                w_id_onehot[i] = 1'b1;
                w_pend_sel     = r_pending[i];
                w_res_sel      = core_result[i*DATA_W +: DATA_W];
            end
        end
    end

    // A busy core is never restarted; asking for one is flagged as an error.
    assign w_launch_req = (r_op == OP_COMPUTE_ALL) ? '1 : w_id_onehot;
    assign w_launch_go  = (r_state == S_LAUNCH) ? (w_launch_req & ~core_busy) : '0;
    assign w_launch_err = (r_state == S_LAUNCH) && (|(w_launch_req & core_busy));
    assign w_rx_fire    = (r_state == S_RX_DATA) && arm_to_fpga_data_valid;
    assign w_tx_fire    = (r_state == S_TX_DATA) && fpga_to_arm_data_ready;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) r_state <= S_IDLE;
        else         r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cmd_err   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (arm_to_fpga_cmd_valid) begin
                    case (w_cmd_op)
                        OP_COMPUTE: begin
                            w_state_nxt = w_cmd_id_ok ? S_LAUNCH : S_SIGNAL_DONE;
                            w_cmd_err   = !w_cmd_id_ok;
                        end
                        OP_COMPUTE_ALL: w_state_nxt = S_LAUNCH;
                        OP_READ_X: begin
                            w_state_nxt = w_cmd_id_ok ? S_RX_DATA : S_SIGNAL_DONE;
                            w_cmd_err   = !w_cmd_id_ok;
                        end
                        OP_READ_E, OP_READ_R, OP_READ_R2, OP_READ_M:
                            w_state_nxt = S_RX_DATA;
                        OP_WRITE_RES: begin
                            w_state_nxt = w_cmd_id_ok ? S_WAIT_RES : S_SIGNAL_DONE;
                            w_cmd_err   = !w_cmd_id_ok;
                        end
                        default: begin
                            w_state_nxt = S_SIGNAL_DONE;
                            w_cmd_err   = 1'b1;
                        end
                    endcase
                end
            end
            S_RX_DATA:     if (arm_to_fpga_data_valid) w_state_nxt = S_SIGNAL_DONE;
            S_LAUNCH:      w_state_nxt = S_SIGNAL_DONE;
            S_WAIT_RES:    if (w_pend_sel) w_state_nxt = S_TX_DATA;
            S_TX_DATA:     if (fpga_to_arm_data_ready) w_state_nxt = S_SIGNAL_DONE;
            S_SIGNAL_DONE: if (arm_to_fpga_done_read) w_state_nxt = S_IDLE;
            default:       w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_op      <= '0;
            r_id      <= '0;
            r_x       <= '0;
            r_e       <= '0;
            r_m       <= '0;
            r_r       <= '0;
            r_r2      <= '0;
            r_t       <= '0;
            r_tx_data <= '0;
            r_pending <= '0;
            r_err     <= 1'b0;
        end else begin
            if (r_state == S_IDLE && arm_to_fpga_cmd_valid) begin
                r_op <= w_cmd_op;
                r_id <= w_cmd_id;
            end
            if (r_state == S_IDLE && w_state_nxt == S_LAUNCH)
                r_t <= TLEN_W'(arm_to_fpga_cmd[31:22]);
            if (w_rx_fire) begin
                case (r_op)
                    OP_READ_X: begin
                        for (int i = 0; i < NUM_CORES; i++)
                            if (r_id == 4'(i)) r_x[i*DATA_W +: DATA_W] <= arm_to_fpga_data;
                    end
                    OP_READ_E:  r_e  <= arm_to_fpga_data;
                    OP_READ_R:  r_r  <= arm_to_fpga_data;
                    OP_READ_R2: r_r2 <= arm_to_fpga_data;
                    OP_READ_M:  r_m  <= arm_to_fpga_data;
                    default: ;
                endcase
            end
            // Clearing beats a coincident core_done so a relaunch never
            // inherits a stale result.
            r_pending <= (r_pending | core_done)
                       & ~(w_launch_go | (w_tx_fire ? w_id_onehot : '0));
            if (r_state == S_WAIT_RES && w_pend_sel)
                r_tx_data <= w_res_sel;
            if (w_cmd_err || w_launch_err)
                r_err <= 1'b1;
        end
    end

    assign arm_to_fpga_done       = (r_state == S_SIGNAL_DONE);
    assign arm_to_fpga_data_ready = w_rx_fire;
    assign fpga_to_arm_data_valid = (r_state == S_TX_DATA);
    assign fpga_to_arm_data       = r_tx_data;
    assign core_x                 = r_x;
    assign core_e                 = r_e;
    assign core_m                 = r_m;
    assign core_r                 = r_r;
    assign core_r2                = r_r2;
    assign core_t                 = r_t;
    assign core_start             = w_launch_go;
    assign leds                   = {r_err, |r_pending, |core_busy, r_state != S_IDLE};

endmodule

// File: tb/tb_rsa_multicore_ctrl.sv
module tb_rsa_multicore_ctrl;

    localparam int DATA_W = 1024;
    localparam int NC     = 2;
    localparam int TW     = 10;

    localparam logic [3:0] OP_COMPUTE     = 4'd0;
    localparam logic [3:0] OP_READ_X      = 4'd1;
    localparam logic [3:0] OP_WRITE_RES   = 4'd2;
    localparam logic [3:0] OP_READ_E      = 4'd3;
    localparam logic [3:0] OP_READ_R      = 4'd5;
    localparam logic [3:0] OP_READ_R2     = 4'd7;
    localparam logic [3:0] OP_READ_M      = 4'd9;
    localparam logic [3:0] OP_COMPUTE_ALL = 4'd11;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    logic [31:0]            arm_to_fpga_cmd;
    logic                   arm_to_fpga_cmd_valid;
    logic                   arm_to_fpga_done;
    logic                   arm_to_fpga_done_read;
    logic                   arm_to_fpga_data_valid;
    logic                   arm_to_fpga_data_ready;
    logic [DATA_W-1:0]      arm_to_fpga_data;
    logic                   fpga_to_arm_data_valid;
    logic                   fpga_to_arm_data_ready;
    logic [DATA_W-1:0]      fpga_to_arm_data;
    logic [NC*DATA_W-1:0]   core_x;
    logic [DATA_W-1:0]      core_e, core_m, core_r, core_r2;
    logic [TW-1:0]          core_t;
    logic [NC-1:0]          core_start, core_busy, core_done;
    logic [NC*DATA_W-1:0]   core_result;
    logic [3:0]             leds;

    rsa_multicore_ctrl #(.DATA_W(DATA_W), .NUM_CORES(NC), .TLEN_W(TW)) dut (
        .clk(clk), .resetn(resetn),
        .arm_to_fpga_cmd(arm_to_fpga_cmd), .arm_to_fpga_cmd_valid(arm_to_fpga_cmd_valid),
        .arm_to_fpga_done(arm_to_fpga_done), .arm_to_fpga_done_read(arm_to_fpga_done_read),
        .arm_to_fpga_data_valid(arm_to_fpga_data_valid),
        .arm_to_fpga_data_ready(arm_to_fpga_data_ready),
        .arm_to_fpga_data(arm_to_fpga_data),
        .fpga_to_arm_data_valid(fpga_to_arm_data_valid),
        .fpga_to_arm_data_ready(fpga_to_arm_data_ready),
        .fpga_to_arm_data(fpga_to_arm_data),
        .core_x(core_x), .core_e(core_e), .core_m(core_m), .core_r(core_r),
        .core_r2(core_r2), .core_t(core_t), .core_start(core_start),
        .core_busy(core_busy), .core_done(core_done), .core_result(core_result),
        .leds(leds)
    );

    // ---------------- scoreboard / reference model ----------------
    int n_pass  = 0;
    int n_total = 0;
    logic [DATA_W-1:0] exp_q[$];

    // What the ARM should observe: loaded operands, result availability, error.
    logic [DATA_W-1:0] mdl_x[NC];
    logic [DATA_W-1:0] mdl_e, mdl_m, mdl_r, mdl_r2;
    logic [TW-1:0]     mdl_t;
    bit                mdl_avail[NC];
    logic [DATA_W-1:0] mdl_res[NC];
    bit                mdl_err;

    // Behavioural cores: configured latency/result, observed start/done counts.
    int                cfg_lat[NC];
    logic [DATA_W-1:0] cfg_res[NC];
    int                start_cnt[NC];
    int                done_cnt[NC];
    time               done_time[NC];

    task automatic check(input string name, input logic [DATA_W-1:0] act,
                         input logic [DATA_W-1:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (low 128 bits)",
                      name, act[127:0], exp[127:0]);
    endtask

    function automatic logic [DATA_W-1:0] rand_data();
        logic [DATA_W-1:0] v;
        for (int i = 0; i < DATA_W/32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    function automatic bit any_avail();
        bit a = 0;
        for (int k = 0; k < NC; k++) a |= mdl_avail[k];
        return a;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < NC; k++) begin
            mdl_x[k] = '0; mdl_avail[k] = 0; mdl_res[k] = '0;
        end
        mdl_e = '0; mdl_m = '0; mdl_r = '0; mdl_r2 = '0; mdl_t = '0; mdl_err = 0;
    endtask

    // Monitor: pops one expected value per accepted outbound result.
    task automatic monitor();
        logic [DATA_W-1:0] e;
        forever begin
            @(negedge clk);
            if (resetn && fpga_to_arm_data_valid && fpga_to_arm_data_ready) begin
                if (exp_q.size() == 0) begin
                    n_total++;
                    $display("FAIL unexpected_result: got 0x%0h, none expected",
                             fpga_to_arm_data[127:0]);
                end else begin
                    e = exp_q.pop_front();
                    check("result_data", fpga_to_arm_data, e);
                end
            end
        end
    endtask

    // Core model: start seen -> busy for cfg_lat cycles -> one-cycle done.
    task automatic core_model();
        int            cnt[NC];
        logic [NC-1:0] nb, nd, st;
        core_busy = '0; core_done = '0; core_result = '0;
        for (int k = 0; k < NC; k++) cnt[k] = 0;
        forever begin
            @(negedge clk);
            st = core_start;
            nb = core_busy;
            nd = '0;
            for (int k = 0; k < NC; k++) begin
                if (core_done[k]) begin done_cnt[k]++; done_time[k] = $time; end
                if (st[k]) start_cnt[k]++;
                if (!resetn) begin
                    nb[k] = 1'b0; cnt[k] = 0;
                end else if (st[k]) begin
                    nb[k] = 1'b1; cnt[k] = cfg_lat[k];
                end else if (nb[k]) begin
                    cnt[k]--;
                    if (cnt[k] <= 0) begin
                        nb[k] = 1'b0; nd[k] = 1'b1;
                        core_result[k*DATA_W +: DATA_W] = cfg_res[k];
                    end
                end
            end
            @(posedge clk); #1;
            core_busy = nb;
            core_done = nd;
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic send_cmd(input logic [3:0] op, input logic [3:0] id, input logic [TW-1:0] t);
        tick();
        arm_to_fpga_cmd       = {t, 14'($urandom), id, op};
        arm_to_fpga_cmd_valid = 1'b1;
        tick();
        arm_to_fpga_cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input string name, input int hold);
        bit seen = 0;
        for (int n = 0; n < 300 && !seen; n++) begin
            @(negedge clk);
            seen = arm_to_fpga_done;
        end
        check({name, "_done_seen"}, seen, 1);
        if (hold > 0) begin
            repeat (hold) @(negedge clk);
            check({name, "_done_held"}, arm_to_fpga_done, 1);
        end
        tick();
        arm_to_fpga_done_read = 1'b1;
        tick();
        arm_to_fpga_done_read = 1'b0;
        @(negedge clk);
        check({name, "_done_cleared"}, {arm_to_fpga_done, leds[0]}, 0);
    endtask

    task automatic check_operands(input string name);
        for (int k = 0; k < NC; k++)
            check($sformatf("%s_core_x%0d", name, k), core_x[k*DATA_W +: DATA_W], mdl_x[k]);
        check({name, "_core_e"},  core_e,  mdl_e);
        check({name, "_core_m"},  core_m,  mdl_m);
        check({name, "_core_r"},  core_r,  mdl_r);
        check({name, "_core_r2"}, core_r2, mdl_r2);
        check({name, "_core_t"},  core_t,  mdl_t);
    endtask

    task automatic load(input logic [3:0] op, input logic [3:0] id,
                        input logic [DATA_W-1:0] data, input int hold);
        int rdy = 0;
        bit got = 0;
        send_cmd(op, id, TW'($urandom));
        arm_to_fpga_data       = data;
        arm_to_fpga_data_valid = 1'b1;
        for (int n = 0; n < 50 && !got; n++) begin
            @(negedge clk);
            if (arm_to_fpga_data_ready) begin rdy++; got = 1; end
        end
        tick();
        arm_to_fpga_data_valid = 1'b0;
        @(negedge clk);
        if (arm_to_fpga_data_ready) rdy++;
        check("rx_ready_pulses", rdy, 1);
        wait_done("load", hold);
        case (op)
            OP_READ_X:  mdl_x[id] = data;
            OP_READ_E:  mdl_e     = data;
            OP_READ_R:  mdl_r     = data;
            OP_READ_R2: mdl_r2    = data;
            OP_READ_M:  mdl_m     = data;
            default: ;
        endcase
    endtask

    // exp_start: which cores the caller knows are idle and must start.
    task automatic compute(input logic [3:0] op, input logic [3:0] id, input logic [TW-1:0] t,
                           input logic [NC-1:0] exp_start, input bit chk_early);
        int            s0[NC], d0[NC];
        logic [NC-1:0] req;
        bit            illegal;
        for (int k = 0; k < NC; k++) begin s0[k] = start_cnt[k]; d0[k] = done_cnt[k]; end
        illegal = !(op == OP_COMPUTE || op == OP_COMPUTE_ALL) || (op == OP_COMPUTE && id >= NC);
        req = '0;
        if (op == OP_COMPUTE_ALL) req = '1;
        else if (op == OP_COMPUTE && id < NC) req[id] = 1'b1;
        send_cmd(op, id, t);
        wait_done("compute", 0);
        for (int k = 0; k < NC; k++) begin
            check($sformatf("start_pulses_core%0d", k), start_cnt[k] - s0[k], exp_start[k]);
            if (chk_early)
                check($sformatf("done_before_core%0d_finish", k), done_cnt[k] - d0[k], 0);
            if (exp_start[k]) begin mdl_avail[k] = 1; mdl_res[k] = cfg_res[k]; end
        end
        if (!illegal) mdl_t = t;
        if (illegal || |(req & ~exp_start)) mdl_err = 1;
        check("core_t", core_t, mdl_t);
        check("led_error", leds[3], mdl_err);
    endtask

    task automatic read_result(input logic [3:0] id, input int hold, input bit chk_lat);
        bit got = 0;
        int d0;
        d0 = done_cnt[id];
        exp_q.push_back(mdl_res[id]);
        send_cmd(OP_WRITE_RES, id, TW'($urandom));
        for (int n = 0; n < 2000 && !got; n++) begin
            @(negedge clk);
            got = fpga_to_arm_data_valid;
        end
        check("result_valid_seen", got, 1);
        if (chk_lat) begin
            check("valid_not_before_core_done", done_cnt[id] - d0, 1);
            // Pulse cycle sets pending, next cycle registers the result.
            check("valid_latency_after_done", $time - done_time[id], 20);
        end
        for (int h = 0; h < hold; h++) begin
            check("tx_hold_stable", {fpga_to_arm_data_valid, fpga_to_arm_data},
                  {1'b1, mdl_res[id]});
            @(negedge clk);
        end
        tick();
        fpga_to_arm_data_ready = 1'b1;
        wait_done("read_result", 0);
        fpga_to_arm_data_ready = 1'b0;
        mdl_avail[id] = 0;
    endtask

    task automatic wait_cores_idle();
        bit idle = 0;
        for (int n = 0; n < 500 && !idle; n++) begin
            @(negedge clk);
            idle = (core_busy == '0) && (core_done == '0);
        end
        check("cores_idle", idle, 1);
        repeat (2) @(negedge clk);
    endtask

    task automatic check_leds(input string name);
        check(name, leds, {mdl_err, any_avail(), 2'b00});
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_ctrl"}, {arm_to_fpga_done, arm_to_fpga_data_ready,
                               fpga_to_arm_data_valid, core_start, leds}, 0);
        check({name, "_tx_data"}, fpga_to_arm_data, 0);
        check_operands(name);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [3:0] rid;
        int         sel;
        bit         got;

        arm_to_fpga_cmd = '0; arm_to_fpga_cmd_valid = 0; arm_to_fpga_done_read = 0;
        arm_to_fpga_data_valid = 0; arm_to_fpga_data = '0; fpga_to_arm_data_ready = 0;
        resetn = 1'b0;
        for (int k = 0; k < NC; k++) begin
            cfg_lat[k] = 20; cfg_res[k] = '0; start_cnt[k] = 0; done_cnt[k] = 0; done_time[k] = 0;
        end
        model_reset();
        fork
            monitor();
            core_model();
        join_none

        repeat (3) @(negedge clk);
        check_all_zero("reset");
        tick();
        resetn = 1'b1;

        // Operand loads
        load(OP_READ_X, 4'd0, DATA_W'('hA5), 3);
        load(OP_READ_E, 4'd0, DATA_W'('hd6db), 0);
        load(OP_READ_M, 4'd0, rand_data(), 0);
        load(OP_READ_R, 4'd0, rand_data(), 0);
        load(OP_READ_R2, 4'd0, rand_data(), 0);
        load(OP_READ_X, 4'd1, rand_data(), 0);
        check("x0_is_a5", core_x[DATA_W-1:0], DATA_W'('hA5));
        check("e_is_d6db", core_e, DATA_W'('hd6db));
        check_operands("loaded");

        // Single-core launch, done returns before the core finishes
        cfg_lat[1] = 40; cfg_res[1] = rand_data();
        compute(OP_COMPUTE, 4'd1, 10'd16, 2'b10, 1);
        check("core_t_16", core_t, 10'd16);
        wait_cores_idle();
        read_result(4'd1, 0, 0);
        check_leds("leds_after_single");

        // Launch all, read back out of completion order
        cfg_lat[0] = 50; cfg_res[0] = DATA_W'('h111);
        cfg_lat[1] = 80; cfg_res[1] = DATA_W'('h222);
        compute(OP_COMPUTE_ALL, 4'd0, TW'($urandom), 2'b11, 1);
        wait_cores_idle();
        check_leds("leds_both_pending");
        read_result(4'd1, 0, 0);
        read_result(4'd0, 0, 0);
        check_leds("leds_all_read");

        // Result requested before the core finishes; ARM stalls ready
        cfg_lat[0] = 30; cfg_res[0] = rand_data();
        compute(OP_COMPUTE, 4'd0, TW'($urandom), 2'b01, 1);
        read_result(4'd0, 5, 1);
        check_leds("leds_after_early_read");

        // Error cases
        compute(4'd15, 4'd0, TW'($urandom), 2'b00, 0);
        compute(OP_COMPUTE, 4'd3, TW'($urandom), 2'b00, 0);
        cfg_lat[0] = 60; cfg_res[0] = rand_data();
        compute(OP_COMPUTE, 4'd0, TW'($urandom), 2'b01, 1);
        compute(OP_COMPUTE, 4'd0, TW'($urandom), 2'b00, 0);
        wait_cores_idle();
        read_result(4'd0, 0, 0);
        check_leds("leds_error_sticky");

        // Randomized traffic
        for (int it = 0; it < 8; it++) begin
            sel = $urandom_range(0, 2);
            if (sel == 0) begin
                case ($urandom_range(0, 4))
                    0: load(OP_READ_X, 4'($urandom_range(0, NC-1)), rand_data(), 0);
                    1: load(OP_READ_E, 4'd0, rand_data(), 0);
                    2: load(OP_READ_R, 4'd0, rand_data(), 0);
                    3: load(OP_READ_R2, 4'd0, rand_data(), 0);
                    default: load(OP_READ_M, 4'd0, rand_data(), 0);
                endcase
                check_operands("rand_load");
            end else if (sel == 1) begin
                rid = 4'($urandom_range(0, NC-1));
                cfg_lat[rid] = $urandom_range(10, 60); cfg_res[rid] = rand_data();
                compute(OP_COMPUTE, rid, TW'($urandom), NC'(1) << rid, 1);
                wait_cores_idle();
                read_result(rid, $urandom_range(0, 3), 0);
            end else begin
                for (int k = 0; k < NC; k++) begin
                    cfg_lat[k] = $urandom_range(10, 60); cfg_res[k] = rand_data();
                end
                compute(OP_COMPUTE_ALL, 4'd0, TW'($urandom), '1, 1);
                wait_cores_idle();
                rid = 4'($urandom_range(0, 1));
                read_result(rid, $urandom_range(0, 3), 0);
                read_result(4'd1 - rid, $urandom_range(0, 3), 0);
            end
            check_leds("rand_leds");
        end

        // Asynchronous reset in the middle of a result transfer
        cfg_lat[1] = 10; cfg_res[1] = rand_data();
        compute(OP_COMPUTE, 4'd1, TW'($urandom), 2'b10, 1);
        wait_cores_idle();
        send_cmd(OP_WRITE_RES, 4'd1, TW'($urandom));
        got = 0;
        for (int n = 0; n < 50 && !got; n++) begin
            @(negedge clk);
            got = fpga_to_arm_data_valid;
        end
        check("pre_reset_tx_valid", got, 1);
        check("pre_reset_tx_data", fpga_to_arm_data, mdl_res[1]);
        check("pre_reset_pending_led", leds[2], 1);
        #2;
        resetn = 1'b0;
        #1;
        model_reset();
        check_all_zero("async_reset");
        repeat (2) @(negedge clk);
        tick();
        resetn = 1'b1;
        load(OP_READ_M, 4'd0, rand_data(), 0);
        check_operands("after_reset");
        check_leds("leds_after_reset");

        check("scoreboard_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not reach the end, time %0t", $time);
        $fatal(1);
    end

endmodule
